// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch (I) and load/store (D), D first.
// Define MEM_ARB_FAIR_EN to add a starve counter that periodically lets a waiting fetch win.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                arb_busy,
  output logic                arb_owner
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t              state_reg, state_next;
  logic                grant_d, grant_i;
  logic                owner_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [STRB_W-1:0]   mem_wstrb_reg;
  logic [DATA_W-1:0]   if_rdata_reg, d_rdata_reg;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_reg;
  logic             force_i;

  // A fetch that has watched LIMIT back-to-back D grants gets the next slot.
  assign force_i = d_req && if_req && (starve_reg == LIMIT);
  assign grant_d = (state_reg == IDLE) && d_req && !force_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
    end else if (grant_d) begin
      if (if_req)
        starve_reg <= (starve_reg == LIMIT) ? LIMIT : starve_reg + 1'b1;
      else
        starve_reg <= '0;
    end else if (grant_i) begin
      starve_reg <= '0;
    end
  end
`else
  assign grant_d = (state_reg == IDLE) && d_req;
`endif

  assign grant_i = (state_reg == IDLE) && if_req && !grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: if (mem_ack) state_next = RESP;
      RESP:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Bus fields are captured once at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg     <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      if (grant_d) begin
        owner_reg     <= 1'b1;
        mem_we_reg    <= d_we;
        mem_addr_reg  <= d_addr;
        mem_wdata_reg <= d_wdata;
        mem_wstrb_reg <= d_wstrb;
      end else if (grant_i) begin
        owner_reg     <= 1'b0;
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= if_addr;
        mem_wdata_reg <= '0;
        mem_wstrb_reg <= '0;
      end
      if (state_reg == BUSY_I && mem_ack)
        if_rdata_reg <= mem_rdata;
      if (state_reg == BUSY_D && mem_ack && !mem_we_reg)
        d_rdata_reg <= mem_rdata;
    end
  end

  // Handshake outputs decode straight from state so reset clears them at once.
  always_comb begin
    mem_req  = (state_reg == BUSY_I) || (state_reg == BUSY_D);
    arb_busy = (state_reg != IDLE);
    if_ready = (state_reg == RESP) && !owner_reg;
    d_ready  = (state_reg == RESP) && owner_reg;
  end

  assign arb_owner = owner_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule
